cpu_controller: RTL and testbench

Sequencer for the 8-bit accumulator CPU. Runs a fixed eight-phase fetch/execute cycle, decodes the 3-bit instruction opcode, and drives every datapath control strobe: address mux select, memory read/write, instruction-register load, program-counter increment/load, accumulator load and data-bus enable. It sits directly upstream of the ALU. The ALU receives the same opcode from the instruction register, and the ALU's `zero` flag feeds back into this block for SKZ.

---
 rtl/cpu_controller.sv | 122 ++++++++++++
 tb/tb_cpu_controller.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - eight-phase fetch/execute sequencer for the 8-bit accumulator CPU
module cpu_controller (
    input  logic       clk,
    input  logic       rst_,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic [2:0] phase,
    output logic       sel,
    output logic       rd,
    output logic       ld_ir,
    output logic       inc_pc,
    output logic       halt,
    output logic       ld_pc,
    output logic       data_e,
    output logic       ld_ac,
    output logic       wr
);

    localparam logic [2:0] PH_INST_ADDR  = 3'd0;
    localparam logic [2:0] PH_INST_FETCH = 3'd1;
    localparam logic [2:0] PH_INST_LOAD  = 3'd2;
    localparam logic [2:0] PH_IDLE       = 3'd3;
    localparam logic [2:0] PH_OP_ADDR    = 3'd4;
    localparam logic [2:0] PH_OP_FETCH   = 3'd5;
    localparam logic [2:0] PH_ALU_OP     = 3'd6;
    localparam logic [2:0] PH_STORE      = 3'd7;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    logic [2:0] phase_q;
    logic       halted;
    logic       is_aluop;
    logic       is_hlt;
    logic       is_skz;
    logic       is_jmp;
    logic       is_sto;

    assign is_aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
                      (opcode == OP_XOR) || (opcode == OP_LDA);
    assign is_hlt   = (opcode == OP_HLT);
    assign is_skz   = (opcode == OP_SKZ);
    assign is_jmp   = (opcode == OP_JMP);
    assign is_sto   = (opcode == OP_STO);

    // HLT freezes the counter in OP_ADDR; only reset leaves that state
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            phase_q <= PH_INST_ADDR;
            halted  <= 1'b0;
        end else if (!halted) begin
            if ((phase_q == PH_OP_ADDR) && is_hlt) begin
                halted <= 1'b1;
            end else begin
                phase_q <= phase_q + 3'd1;
            end
        end
    end

    assign phase = phase_q;

    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        halt   = 1'b0;
        ld_pc  = 1'b0;
        data_e = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
        if (halted) begin
            halt = 1'b1;
        end else begin
            case (phase_q)
                PH_INST_ADDR: begin
                    sel = 1'b1;
                end
                PH_INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                PH_INST_LOAD, PH_IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                PH_OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = is_hlt;
                end
                PH_OP_FETCH: begin
                    rd = is_aluop;
                end
                PH_ALU_OP: begin
                    rd     = is_aluop;
                    inc_pc = is_skz & zero;
                    ld_pc  = is_jmp;
                    data_e = is_sto;
                end
                PH_STORE: begin
                    rd     = is_aluop;
                    ld_ac  = is_aluop;
                    inc_pc = is_jmp;
                    ld_pc  = is_jmp;
                    data_e = is_sto;
                    wr     = is_sto;
                end
                default: begin
                    sel = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_controller.sv
// tb/tb_cpu_controller.sv - directed self-checking bench for cpu_controller
module tb_cpu_controller;

    logic       clk;
    logic       rst_;
    logic [2:0] opcode;
    logic       zero;
    logic [2:0] phase;
    logic       sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr;

    int checks = 0;
    int errors = 0;

    cpu_controller dut (
        .clk    (clk),
        .rst_   (rst_),
        .opcode (opcode),
        .zero   (zero),
        .phase  (phase),
        .sel    (sel),
        .rd     (rd),
        .ld_ir  (ld_ir),
        .inc_pc (inc_pc),
        .halt   (halt),
        .ld_pc  (ld_pc),
        .data_e (data_e),
        .ld_ac  (ld_ac),
        .wr     (wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // strobe vector order: sel rd ld_ir inc_pc halt ld_pc data_e ld_ac wr
    logic [8:0] strobes;
    assign strobes = {sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr};

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    localparam logic [8:0] S_P0  = 9'b100000000;
    localparam logic [8:0] S_P1  = 9'b110000000;
    localparam logic [8:0] S_P2  = 9'b111000000;
    localparam logic [8:0] S_INC = 9'b000100000;
    localparam logic [8:0] S_NIL = 9'b000000000;
    localparam logic [8:0] S_HALTED = 9'b000010000;

    // expected strobes per phase, phase 0 in the most significant slot
    localparam logic [71:0] T_ADD  = {S_P0, S_P1, S_P2, S_P2, S_INC, 9'b010000000, 9'b010000000, 9'b010000010};
    localparam logic [71:0] T_STO  = {S_P0, S_P1, S_P2, S_P2, S_INC, S_NIL, 9'b000000100, 9'b000000101};
    localparam logic [71:0] T_SKZ1 = {S_P0, S_P1, S_P2, S_P2, S_INC, S_NIL, 9'b000100000, S_NIL};
    localparam logic [71:0] T_SKZ0 = {S_P0, S_P1, S_P2, S_P2, S_INC, S_NIL, S_NIL, S_NIL};
    localparam logic [71:0] T_JMP  = {S_P0, S_P1, S_P2, S_P2, S_INC, S_NIL, 9'b000001000, 9'b000101000};
    localparam logic [71:0] T_HLT  = {S_P0, S_P1, S_P2, S_P2, 9'b000110000, S_NIL, S_NIL, S_NIL};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Entered at a falling edge with the DUT in phase `from`; leaves at the falling edge after phase `to`.
    // Phases 0-2 see a scrambled opcode, which must not change any strobe.
    task automatic run_phases(input string name, input logic [2:0] op, input logic z,
                              input logic [71:0] tbl, input int from, input int to);
        logic [8:0] exp;
        for (int p = from; p <= to; p++) begin
            opcode = (p < 3) ? (op ^ 3'(p + 1)) : op;
            zero   = (p == 6) ? z : ~z;
            #1;
            exp = tbl[(7 - p) * 9 +: 9];
            check($sformatf("%s phase@%0d", name, p), 32'(phase), 32'(p));
            check($sformatf("%s strobes@%0d", name, p), 32'(strobes), 32'(exp));
            @(negedge clk);
        end
    endtask

    initial begin
        rst_   = 1'b0;
        opcode = OP_ADD;
        zero   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset phase", 32'(phase), 32'd0);
        check("reset strobes", 32'(strobes), 32'(S_P0));
        rst_ = 1'b1;

        run_phases("add", OP_ADD, 1'b0, T_ADD, 0, 7);
        run_phases("sto", OP_STO, 1'b0, T_STO, 0, 7);
        run_phases("skz_z1", OP_SKZ, 1'b1, T_SKZ1, 0, 7);
        run_phases("skz_z0", OP_SKZ, 1'b0, T_SKZ0, 0, 7);
        run_phases("jmp", OP_JMP, 1'b0, T_JMP, 0, 7);

        run_phases("hlt", OP_HLT, 1'b0, T_HLT, 0, 4);
        for (int i = 0; i < 20; i++) begin
            check($sformatf("halted phase c%0d", i), 32'(phase), 32'd4);
            check($sformatf("halted strobes c%0d", i), 32'(strobes), 32'(S_HALTED));
            @(negedge clk);
        end

        // asynchronous reset between edges while halted
        #2 rst_ = 1'b0;
        #1;
        check("halt reset phase", 32'(phase), 32'd0);
        check("halt reset strobes", 32'(strobes), 32'(S_P0));
        @(negedge clk);
        rst_ = 1'b1;
        run_phases("post_halt_add", OP_ADD, 1'b0, T_ADD, 0, 7);

        // reset in the middle of a store's ALU_OP phase
        run_phases("mid_sto", OP_STO, 1'b0, T_STO, 0, 5);
        opcode = OP_STO;
        #1;
        check("mid phase6", 32'(phase), 32'd6);
        check("mid data_e before", 32'(data_e), 32'd1);
        rst_ = 1'b0;
        #1;
        check("mid data_e after", 32'(data_e), 32'd0);
        check("mid wr after", 32'(wr), 32'd0);
        check("mid phase after", 32'(phase), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("mid wr held c%0d", i), 32'(wr), 32'd0);
            check($sformatf("mid strobes held c%0d", i), 32'(strobes), 32'(S_P0));
        end
        rst_ = 1'b1;
        run_phases("post_mid_sto", OP_STO, 1'b0, T_STO, 0, 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
